// File: rtl/gf_ifetch_pkg.sv
// Shared fetch-stage definitions: default widths and the fetch queue entry layout.
// Both gf_ifetch and gf_ifetch_queue take their parameter defaults from here.
package gf_ifetch_pkg;

  localparam int GF_ADDR_LEN  = 64;
  localparam int GF_INST_LEN  = 32;
  localparam int GF_INST_BLEN = 4;

  // One fetch queue slot; the queue keeps each field in its own array with this ordering.
  typedef struct packed {
    logic [GF_ADDR_LEN-1:0] pc;
    logic [GF_INST_LEN-1:0] inst;
    logic                   err;
    logic                   filled;
  } gf_fq_entry_t;

  function automatic int gf_count_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/gf_ifetch_queue.sv
// Fetch queue storage: entries are allocated at issue, filled in order by responses
// and popped from the head, with wrap-bit pointers so a full queue differs from an empty one.
module gf_ifetch_queue
  import gf_ifetch_pkg::*;
#(
  parameter int ADDR_LEN = GF_ADDR_LEN,
  parameter int INST_LEN = GF_INST_LEN,
  parameter int QDEPTH   = 4,
  localparam int PW      = $clog2(QDEPTH),
  localparam int CW      = gf_count_bits(QDEPTH)
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_alloc,
  input  logic [ADDR_LEN-1:0] i_alloc_pc,
  input  logic                i_fill,
  input  logic [INST_LEN-1:0] i_fill_inst,
  input  logic                i_fill_err,
  input  logic                i_pop,
  input  logic                i_clear,
  output logic [CW-1:0]       o_occupancy,
  output logic [CW-1:0]       o_unfilled,
  output logic                o_head_filled,
  output logic [ADDR_LEN-1:0] o_head_pc,
  output logic [INST_LEN-1:0] o_head_inst,
  output logic                o_head_err
);

  logic [CW-1:0]       r_alloc_ptr;
  logic [CW-1:0]       r_fill_ptr;
  logic [CW-1:0]       r_rd_ptr;
  logic [ADDR_LEN-1:0] r_pc     [QDEPTH];
  logic [INST_LEN-1:0] r_inst   [QDEPTH];
  logic                r_err    [QDEPTH];
  logic                r_filled [QDEPTH];

  logic [PW-1:0] w_alloc_idx;
  logic [PW-1:0] w_fill_idx;
  logic [PW-1:0] w_rd_idx;

  assign w_alloc_idx = r_alloc_ptr[PW-1:0];
  assign w_fill_idx  = r_fill_ptr[PW-1:0];
  assign w_rd_idx    = r_rd_ptr[PW-1:0];

  // Alloc, fill and pop always target distinct slots, so all three may land in one cycle.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_rd_ptr    <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_pc[i]     <= '0;
        r_inst[i]   <= '0;
        r_err[i]    <= 1'b0;
        r_filled[i] <= 1'b0;
      end
    end else if (i_clear) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_rd_ptr    <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_filled[i] <= 1'b0;
      end
    end else begin
      if (i_alloc) begin
        r_pc[w_alloc_idx]     <= i_alloc_pc;
        r_filled[w_alloc_idx] <= 1'b0;
        r_alloc_ptr           <= r_alloc_ptr + CW'(1);
      end
      if (i_fill) begin
        r_inst[w_fill_idx]   <= i_fill_inst;
        r_err[w_fill_idx]    <= i_fill_err;
        r_filled[w_fill_idx] <= 1'b1;
        r_fill_ptr           <= r_fill_ptr + CW'(1);
      end
      if (i_pop) begin
        r_filled[w_rd_idx] <= 1'b0;
        r_rd_ptr           <= r_rd_ptr + CW'(1);
      end
    end
  end

  assign o_occupancy   = r_alloc_ptr - r_rd_ptr;
  assign o_unfilled    = r_alloc_ptr - r_fill_ptr;
  assign o_head_filled = r_filled[w_rd_idx];
  assign o_head_pc     = r_pc[w_rd_idx];
  assign o_head_inst   = r_inst[w_rd_idx];
  assign o_head_err    = r_err[w_rd_idx];

endmodule

// File: rtl/gf_ifetch.sv
// Instruction fetch front end: issues PC-addressed memory reads under queue credit,
// drops responses owed to redirected requests and hands filled entries to decode in order.
module gf_ifetch
  import gf_ifetch_pkg::*;
#(
  parameter int ADDR_LEN  = GF_ADDR_LEN,
  parameter int INST_LEN  = GF_INST_LEN,
  parameter int INST_BLEN = GF_INST_BLEN,
  parameter int QDEPTH    = 4
) (
  input  logic                clk,
  input  logic                i_sig_rst,
  input  logic [ADDR_LEN-1:0] i_pc,
  input  logic                i_sig_flush,
  output logic [ADDR_LEN-1:0] o_last_pc,
  output logic                o_sig_req_valid,
  output logic [ADDR_LEN-1:0] o_req_addr,
  input  logic                i_sig_req_ready,
  input  logic                i_sig_rsp_valid,
  input  logic [INST_LEN-1:0] i_rsp_data,
  input  logic                i_sig_rsp_err,
  output logic                o_sig_inst_valid,
  output logic [INST_LEN-1:0] o_inst,
  output logic [ADDR_LEN-1:0] o_inst_pc,
  output logic                o_sig_inst_err,
  input  logic                i_sig_inst_ready
);

  localparam int DW = gf_count_bits(QDEPTH);
  localparam logic [DW:0] CREDIT_LIMIT = (DW + 1)'(QDEPTH);

  logic [DW-1:0] r_discard;
  logic [DW-1:0] w_discard_nxt;
  logic [DW-1:0] w_occupancy;
  logic [DW-1:0] w_unfilled;
  logic [DW:0]   w_credit_used;
  logic          w_req_fire;
  logic          w_fill;
  logic          w_pop;
  logic          w_head_filled;

  // Responses still owed to abandoned requests hold credit exactly like live entries.
  assign w_credit_used   = {1'b0, w_occupancy} + {1'b0, r_discard};
  assign o_sig_req_valid = !i_sig_rst && !i_sig_flush && (w_credit_used < CREDIT_LIMIT);
  assign o_req_addr      = i_pc;
  assign w_req_fire      = o_sig_req_valid && i_sig_req_ready;
  assign o_last_pc       = w_req_fire ? i_pc : (i_pc - ADDR_LEN'(INST_BLEN));

  assign w_fill           = i_sig_rsp_valid && (r_discard == '0) && !i_sig_flush;
  assign o_sig_inst_valid = !i_sig_rst && w_head_filled && !i_sig_flush;
  assign w_pop            = o_sig_inst_valid && i_sig_inst_ready;

  // On redirect every unfilled entry turns into a response to drop; one arriving now is already gone.
  always_comb begin
    w_discard_nxt = r_discard;
    if (i_sig_flush) begin
      w_discard_nxt = r_discard + w_unfilled - DW'(i_sig_rsp_valid);
    end else if (i_sig_rsp_valid && (r_discard != '0)) begin
      w_discard_nxt = r_discard - DW'(1);
    end
  end

  always_ff @(posedge clk or posedge i_sig_rst) begin
    if (i_sig_rst) begin
      r_discard <= '0;
    end else begin
      r_discard <= w_discard_nxt;
    end
  end

  gf_ifetch_queue #(
    .ADDR_LEN (ADDR_LEN),
    .INST_LEN (INST_LEN),
    .QDEPTH   (QDEPTH)
  ) u_queue (
    .clk           (clk),
    .i_rst         (i_sig_rst),
    .i_alloc       (w_req_fire),
    .i_alloc_pc    (i_pc),
    .i_fill        (w_fill),
    .i_fill_inst   (i_rsp_data),
    .i_fill_err    (i_sig_rsp_err),
    .i_pop         (w_pop),
    .i_clear       (i_sig_flush),
    .o_occupancy   (w_occupancy),
    .o_unfilled    (w_unfilled),
    .o_head_filled (w_head_filled),
    .o_head_pc     (o_inst_pc),
    .o_head_inst   (o_inst),
    .o_head_err    (o_sig_inst_err)
  );

`ifndef SYNTHESIS
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (i_sig_rst)
    !(i_sig_rsp_valid && (r_discard == '0) && (w_unfilled == '0)));
  a_discard_bound: assert property (@(posedge clk) disable iff (i_sig_rst)
    ({1'b0, r_discard} <= CREDIT_LIMIT));
`endif

endmodule
